// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types and the victim write buffer controller states.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] l1_cache_line;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_MISS = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;

endpackage

// File: rtl/victim_buffer_cam.sv
// Fully associative address match across all buffer entries.
module victim_buffer_cam #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic [DEPTH-1:0]             hit_vec,
    output logic                         hit
);

    // Coalescing keeps addresses unique, so the hit vector is at most one-hot.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid[i] && (entry_addr[i] == lookup_addr);
        end
    end

    assign hit = |hit_vec;

endmodule

// File: rtl/victim_write_buffer.sv
// Victim write buffer between L1 and physical memory: buffers evicted lines,
// serves read hits from the buffer and drains entries to memory when idle or full.
module victim_write_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $bits(lc3b_word),
    parameter int LINE_W = $bits(l1_cache_line),
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              source_read,
    input  logic              source_write,
    input  logic [ADDR_W-1:0] source_addr,
    input  logic [LINE_W-1:0] source_data,
    output logic              out_resp,
    output logic [LINE_W-1:0] out_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic [CW-1:0]     count,
    output logic              full
);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][LINE_W-1:0] data_q;
    logic [PW-1:0]                head_q, tail_q;
    logic [CW-1:0]                count_q;
    logic [1:0]                   state_q, state_d;

    logic [DEPTH-1:0]  hit_vec;
    logic              hit;
    logic [LINE_W-1:0] hit_data;
    logic              push, pop, coalesce;

    victim_buffer_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_cam (
        .valid       (valid_q),
        .entry_addr  (addr_q),
        .lookup_addr (source_addr),
        .hit_vec     (hit_vec),
        .hit         (hit)
    );

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) hit_data = hit_data | data_q[i];
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));

    // Outputs are gated by reset so strobes drop without waiting for a clock edge.
    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        pop        = 1'b0;
        coalesce   = 1'b0;
        out_resp   = 1'b0;
        out_rdata  = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (source_read) begin
                        if (hit) begin
                            out_resp  = 1'b1;
                            out_rdata = hit_data;
                        end else begin
                            pmem_read = 1'b1;
                            pmem_addr = source_addr;
                            out_resp  = pmem_resp;
                            out_rdata = pmem_rdata;
                            if (!pmem_resp) state_d = ST_READ_MISS;
                        end
                    end else if (source_write) begin
                        if (hit) begin
                            coalesce = 1'b1;
                            out_resp = 1'b1;
                        end else if (!full) begin
                            push     = 1'b1;
                            out_resp = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (count_q != '0) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_READ_MISS: begin
                    pmem_read = 1'b1;
                    pmem_addr = source_addr;
                    if (pmem_resp) begin
                        out_resp  = 1'b1;
                        out_rdata = pmem_rdata;
                        state_d   = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    pmem_write = 1'b1;
                    pmem_addr  = addr_q[head_q];
                    pmem_wdata = data_q[head_q];
                    if (pmem_resp) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= source_addr;
                data_q[tail_q]  <= source_data;
                tail_q          <= tail_q + 1'b1;
                count_q         <= count_q + 1'b1;
            end
            if (coalesce) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (hit_vec[i]) data_q[i] <= source_data;
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
                count_q         <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed bench for victim_write_buffer with a queue-based reference model.
module tb_victim_write_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         source_read, source_write;
    logic [15:0]  source_addr;
    logic [127:0] source_data;
    logic         out_resp;
    logic [127:0] out_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic [2:0]   count;
    logic         full;

    always #5 clk = ~clk;

    victim_write_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .source_read  (source_read),
        .source_write (source_write),
        .source_addr  (source_addr),
        .source_data  (source_data),
        .out_resp     (out_resp),
        .out_rdata    (out_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr    (pmem_addr),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .count        (count),
        .full         (full)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder: answers a request in its lat-th consecutive cycle.
    int lat = 1;
    int mcnt = 0;
    bit force_resp = 1'b0;
    initial begin
        pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (pmem_read || pmem_write) mcnt++;
            else mcnt = 0;
            pmem_resp = ((pmem_read || pmem_write) && mcnt >= lat) || force_resp;
            if (pmem_resp) mcnt = 0;
        end
    end

    // Reference model: FIFO of lines plus "waiting on memory" flags.
    typedef struct packed {
        logic [15:0]  a;
        logic [127:0] d;
    } ent_t;
    ent_t         mq[$];
    ent_t         wlog[$];
    ent_t         popped;
    bit           m_miss = 1'b0;
    bit           m_drain = 1'b0;
    int           hit_i, n_mq;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    logic         e_resp, e_pr, e_pw;
    logic [15:0]  e_addr;
    logic [127:0] e_rdata, e_wdata;

    always @(negedge clk) begin
        if (pmem_read) rd_cnt++;
        if (pmem_write) wr_cnt++;
        if (!reset && pmem_write && pmem_resp) wlog.push_back('{pmem_addr, pmem_wdata});
        check("rw_exclusive", pmem_read & pmem_write, 1'b0);
        if (reset) begin
            check("rst_resp", out_resp, 1'b0);
            check("rst_pread", pmem_read, 1'b0);
            check("rst_pwrite", pmem_write, 1'b0);
            check("rst_full", full, 1'b0);
            check("rst_count", count, 0);
            check("rst_paddr", pmem_addr, 0);
            check("rst_wdata", pmem_wdata, 0);
            check("rst_rdata", out_rdata, 0);
            mq.delete();
            m_miss  = 1'b0;
            m_drain = 1'b0;
        end else begin
            e_resp = 0; e_pr = 0; e_pw = 0;
            e_addr = '0; e_rdata = '0; e_wdata = '0;
            n_mq = mq.size();
            hit_i = -1;
            foreach (mq[i]) if (mq[i].a == source_addr) hit_i = i;
            if (m_drain) begin
                e_pw = 1; e_addr = mq[0].a; e_wdata = mq[0].d;
                if (pmem_resp) begin
                    popped = mq.pop_front();
                    m_drain = 1'b0;
                end
            end else if (m_miss) begin
                e_pr = 1; e_addr = source_addr;
                if (pmem_resp) begin
                    e_resp = 1; e_rdata = pmem_rdata; m_miss = 1'b0;
                end
            end else if (source_read) begin
                if (hit_i >= 0) begin
                    e_resp = 1; e_rdata = mq[hit_i].d;
                end else begin
                    e_pr = 1; e_addr = source_addr;
                    e_resp = pmem_resp; e_rdata = pmem_rdata;
                    if (!pmem_resp) m_miss = 1'b1;
                end
            end else if (source_write) begin
                if (hit_i >= 0) begin
                    mq[hit_i].d = source_data; e_resp = 1;
                end else if (n_mq < 4) begin
                    mq.push_back('{source_addr, source_data}); e_resp = 1;
                end else begin
                    m_drain = 1'b1;
                end
            end else if (n_mq > 0) begin
                m_drain = 1'b1;
            end
            check("m_resp", out_resp, e_resp);
            check("m_pread", pmem_read, e_pr);
            check("m_pwrite", pmem_write, e_pw);
            check("m_count", count, n_mq);
            check("m_full", full, n_mq == 4);
            if (e_pr || e_pw) check("m_paddr", pmem_addr, e_addr);
            if (e_pw) check("m_pwdata", pmem_wdata, e_wdata);
            if (e_resp && source_read) check("m_rdata", out_rdata, e_rdata);
        end
    end

    // Entered and left at posedge+1; holds the strobe until out_resp.
    task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] d,
                       output int cyc, output logic [127:0] rdat);
        bit got = 1'b0;
        source_read  = rd;
        source_write = wr;
        source_addr  = a;
        source_data  = d;
        cyc  = 0;
        rdat = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            cyc++;
            if (out_resp) begin
                got  = 1'b1;
                rdat = out_rdata;
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("req_timeout", 1'b0, 1'b1);
        source_read  = 1'b0;
        source_write = 1'b0;
    endtask

    task automatic idle(input int n);
        source_read  = 1'b0;
        source_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int           cyc;
    logic [127:0] rdat;
    localparam logic [127:0] D_A = 128'hAAAA_0001;
    localparam logic [127:0] D_B = 128'hBBBB_0002;
    localparam logic [127:0] D1  = 128'h1111_1111;
    localparam logic [127:0] D2  = 128'h2222_2222;
    localparam logic [127:0] D3  = 128'h3333_3333;
    localparam logic [127:0] RR  = 128'hDEAD_BEEF_CAFE;

    initial begin
        reset = 1'b1;
        source_read = 1'b0; source_write = 1'b0;
        source_addr = '0; source_data = '0; pmem_rdata = '0;
        #3;
        check("init_resp", out_resp, 1'b0);
        check("init_count", count, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two writes then idle drain in FIFO order.
        req(0, 1, 16'h1000, D_A, cyc, rdat);
        check("wA_latency", cyc, 1);
        req(0, 1, 16'h2000, D_B, cyc, rdat);
        check("wB_latency", cyc, 1);
        check("two_count", count, 2);
        wlog.delete();
        idle(8);
        check("drain_count", count, 0);
        check("drain_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("drain0_addr", wlog[0].a, 16'h1000);
            check("drain1_addr", wlog[1].a, 16'h2000);
            check("drain1_data", wlog[1].d, D_B);
        end

        // Coalescing.
        wlog.delete();
        req(0, 1, 16'h1000, D1, cyc, rdat);
        req(0, 1, 16'h1000, D2, cyc, rdat);
        check("coal_count", count, 1);
        idle(6);
        check("coal_n", wlog.size(), 1);
        if (wlog.size() == 1) check("coal_data", wlog[0].d, D2);

        // Full buffer forces a drain before the fifth write lands.
        wlog.delete();
        for (int i = 1; i <= 4; i++) begin
            req(0, 1, 16'(i * 16'h1000), 128'(i), cyc, rdat);
        end
        check("fill_count", count, 4);
        check("fill_full", full, 1'b1);
        lat = 2;
        req(0, 1, 16'h5000, 128'h5, cyc, rdat);
        check("w5_latency", cyc, 4);
        check("w5_count", count, 4);
        check("w5_drained", wlog.size(), 1);
        if (wlog.size() == 1) check("w5_head", wlog[0].a, 16'h1000);
        idle(20);
        check("w5_all", wlog.size(), 5);
        if (wlog.size() == 5) check("w5_last", wlog[4].a, 16'h5000);

        // Read hit served from the buffer.
        lat = 1;
        req(0, 1, 16'h3000, D3, cyc, rdat);
        rd_cnt = 0;
        req(1, 0, 16'h3000, '0, cyc, rdat);
        check("hit_latency", cyc, 1);
        check("hit_data", rdat, D3);
        check("hit_no_pread", rd_cnt, 0);
        idle(6);

        // Read miss with a three-cycle memory.
        lat = 3;
        pmem_rdata = RR;
        rd_cnt = 0;
        req(1, 0, 16'h4000, '0, cyc, rdat);
        check("miss_latency", cyc, 3);
        check("miss_data", rdat, RR);
        check("miss_pread_cycles", rd_cnt, 3);

        // Simultaneous read and write: write is dropped.
        lat = 1;
        wlog.delete();
        req(1, 1, 16'h7000, 128'h77, cyc, rdat);
        check("rw_latency", cyc, 1);
        idle(3);
        check("rw_count", count, 0);
        check("rw_no_drain", wlog.size(), 0);

        // Reset in the middle of a drain.
        lat = 5;
        req(0, 1, 16'h8000, 128'h88, cyc, rdat);
        @(posedge clk); #1;
        check("pre_rst_pwrite", pmem_write, 1'b1);
        check("pre_rst_paddr", pmem_addr, 16'h8000);
        reset = 1'b1;
        #1;
        check("rst_async_pwrite", pmem_write, 1'b0);
        check("rst_async_count", count, 0);
        wlog.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        wr_cnt = 0;
        force_resp = 1'b1;
        @(posedge clk); #1;
        force_resp = 1'b0;
        idle(4);
        check("post_rst_count", count, 0);
        check("post_rst_no_write", wr_cnt, 0);
        check("post_rst_wlog", wlog.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
